// File: rtl/matrix_accumulator_array.sv
// Multi-channel saturating tile accumulator.
// Sums len input beats per channel and presents the totals until handed off.
module matrix_accumulator_array #(
  parameter int N_CH      = 4,
  parameter int IN_WIDTH  = 16,
  parameter int ACC_WIDTH = 32,
  parameter int CNT_WIDTH = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      start,
  input  logic [CNT_WIDTH-1:0]      len,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N_CH*IN_WIDTH-1:0]  in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N_CH*ACC_WIDTH-1:0] out_data,
  output logic [N_CH-1:0]           out_ovf,
  output logic                      busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] len_q, len_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] cnt_inc;
  logic [ACC_WIDTH-1:0] acc_q [N_CH];
  logic [ACC_WIDTH-1:0] acc_d [N_CH];
  logic [ACC_WIDTH-1:0] sat_w [N_CH];
  logic [N_CH-1:0]      ovf_q, ovf_d;
  logic [N_CH-1:0]      vf_w;
  logic                 go;
  logic                 beat;
  logic                 last;

  assign go      = (state_q == IDLE) && start;
  assign beat    = (state_q == ACCUM) && in_valid;
  assign cnt_inc = cnt_q + 1'b1;
  assign last    = beat && (cnt_inc == len_q);

  // One guard bit catches overflow; clamp toward the sign of the true sum.
  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    logic [ACC_WIDTH:0] sum;
    assign sum = {acc_q[k][ACC_WIDTH-1], acc_q[k]}
               + {{(ACC_WIDTH+1-IN_WIDTH){in_data[k*IN_WIDTH+IN_WIDTH-1]}},
                  in_data[k*IN_WIDTH +: IN_WIDTH]};
    assign vf_w[k]  = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
    assign sat_w[k] = !vf_w[k] ? sum[ACC_WIDTH-1:0] :
                      sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} :
                                       {1'b0, {(ACC_WIDTH-1){1'b1}}};
    assign out_data[k*ACC_WIDTH +: ACC_WIDTH] = acc_q[k];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (start)     state_d = ACCUM;
        ACCUM:   if (last)      state_d = DRAIN;
        DRAIN:   if (out_ready) state_d = IDLE;
        default:                state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      ACCUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      DRAIN: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: ;
    endcase
  end

  assign out_ovf = ovf_q;

  always_comb begin
    len_d = len_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    for (int k = 0; k < N_CH; k++) acc_d[k] = acc_q[k];
    if (clear) begin
      cnt_d = '0;
      ovf_d = '0;
      for (int k = 0; k < N_CH; k++) acc_d[k] = '0;
    end else if (go) begin
      len_d = (len == '0) ? CNT_WIDTH'(1) : len;
      cnt_d = '0;
      ovf_d = '0;
      for (int k = 0; k < N_CH; k++) acc_d[k] = '0;
    end else if (beat) begin
      cnt_d = cnt_inc;
      ovf_d = ovf_q | vf_w;
      for (int k = 0; k < N_CH; k++) acc_d[k] = sat_w[k];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      len_q <= '0;
      cnt_q <= '0;
      ovf_q <= '0;
      for (int k = 0; k < N_CH; k++) acc_q[k] <= '0;
    end else begin
      len_q <= len_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      for (int k = 0; k < N_CH; k++) acc_q[k] <= acc_d[k];
    end
  end

endmodule

// File: tb/tb_matrix_accumulator_array.sv
// Directed and randomized checks of matrix_accumulator_array
// against an integer saturating-sum model.
module tb_matrix_accumulator_array;

  localparam int NC = 4;
  localparam int IW = 16;
  localparam int AW = 17;
  localparam int CW = 8;
  localparam longint AMAX = (longint'(1) << (AW-1)) - 1;
  localparam longint AMIN = -(longint'(1) << (AW-1));

  logic             clock     = 1'b0;
  logic             reset     = 1'b1;
  logic             clear     = 1'b0;
  logic             start     = 1'b0;
  logic [CW-1:0]    len       = '0;
  logic             in_valid  = 1'b0;
  logic             in_ready;
  logic [NC*IW-1:0] in_data   = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [NC*AW-1:0] out_data;
  logic [NC-1:0]    out_ovf;
  logic             busy;

  int n_chk  = 0;
  int n_fail = 0;

  longint          macc [NC];
  logic [NC-1:0]   movf;

  matrix_accumulator_array #(
    .N_CH(NC), .IN_WIDTH(IW), .ACC_WIDTH(AW), .CNT_WIDTH(CW)
  ) dut (
    .clock(clock), .reset(reset), .clear(clear), .start(start),
    .len(len), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ovf(out_ovf), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  function automatic logic [NC*IW-1:0] pk(input int c0, input int c1,
                                          input int c2, input int c3);
    logic [NC*IW-1:0] r;
    r[0*IW +: IW] = c0[IW-1:0];
    r[1*IW +: IW] = c1[IW-1:0];
    r[2*IW +: IW] = c2[IW-1:0];
    r[3*IW +: IW] = c3[IW-1:0];
    return r;
  endfunction

  function automatic longint chv(input int k);
    logic [AW-1:0] f;
    f = out_data[k*AW +: AW];
    return longint'($signed(f));
  endfunction

  function automatic logic [NC*AW-1:0] exp_data();
    logic [NC*AW-1:0] r;
    longint t;
    for (int k = 0; k < NC; k++) begin
      t = macc[k];
      r[k*AW +: AW] = t[AW-1:0];
    end
    return r;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < NC; k++) macc[k] = 0;
    movf = '0;
  endtask

  task automatic model_beat(input logic [NC*IW-1:0] d);
    logic [IW-1:0] f;
    longint s;
    for (int k = 0; k < NC; k++) begin
      f = d[k*IW +: IW];
      s = macc[k] + longint'($signed(f));
      if (s > AMAX) begin s = AMAX; movf[k] = 1'b1; end
      if (s < AMIN) begin s = AMIN; movf[k] = 1'b1; end
      macc[k] = s;
    end
  endtask

  task automatic begin_tile(input logic [CW-1:0] l);
    start = 1'b1;
    len   = l;
    tick();
    start = 1'b0;
    model_clear();
    chk("accum_in_ready", in_ready, 1);
  endtask

  task automatic feed(input logic [NC*IW-1:0] d, input logic v);
    in_valid = v;
    in_data  = d;
    tick();
    in_valid = 1'b0;
    if (v) model_beat(d);
  endtask

  task automatic check_result(input string tag);
    chk({tag, "_out_valid"}, out_valid, 1);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_data"}, out_data, exp_data());
    chk({tag, "_ovf"}, out_ovf, movf);
  endtask

  task automatic finish_drain(input int hold);
    logic [NC*AW-1:0] snap;
    snap = out_data;
    out_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, snap);
      chk("hold_busy", busy, 1);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("drain_busy", busy, 0);
    chk("drain_valid", out_valid, 0);
    chk("drain_keep", out_data, exp_data());
  endtask

  initial begin
    logic [NC*IW-1:0] d;
    int eff, got;
    logic v;
    logic [CW-1:0] l;

    // asynchronous reset at start
    #2 reset = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", out_data, 0);
    chk("rst_ovf", out_ovf, 0);
    tick();
    reset = 1'b1;
    tick();
    chk("idle_busy", busy, 0);
    model_clear();

    // basic tile
    begin_tile(8'd3);
    feed(pk(1, 0, 0, -5), 1'b1);
    feed(pk(2, 0, 0, -5), 1'b1);
    chk("basic_not_yet", out_valid, 0);
    feed(pk(3, 0, 0, -5), 1'b1);
    check_result("basic");
    chk("basic_ch0", chv(0), 6);
    chk("basic_ch3", chv(3), -15);
    finish_drain(0);

    // positive saturation with an independent neighbour
    begin_tile(8'd4);
    repeat (4) feed(pk(1, 32767, 0, 0), 1'b1);
    check_result("satp");
    chk("satp_ch1", chv(1), 65535);
    chk("satp_ch0", chv(0), 4);
    chk("satp_ovf", out_ovf, 4'b0010);
    finish_drain(5);

    // negative saturation
    begin_tile(8'd4);
    repeat (4) feed(pk(0, 0, -32768, 0), 1'b1);
    check_result("satn");
    chk("satn_ch2", chv(2), -65536);
    chk("satn_ovf", out_ovf, 4'b0100);
    finish_drain(1);

    // bubbles
    begin_tile(8'd2);
    feed(pk(10, 20, -30, 40), 1'b1);
    feed(pk(500, 500, 500, 500), 1'b0);
    feed(pk(600, 600, 600, 600), 1'b0);
    chk("bub_not_yet", out_valid, 0);
    feed(pk(-4, 1, 2, 3), 1'b1);
    check_result("bub");
    chk("bub_ch0", chv(0), 6);
    chk("bub_ch2", chv(2), -28);
    finish_drain(0);

    // len of zero behaves as one beat
    begin_tile(8'd0);
    feed(pk(11, -3, 0, 5), 1'b1);
    check_result("len0");
    chk("len0_ch1", chv(1), -3);
    finish_drain(0);

    // clear coincident with an accepted beat
    begin_tile(8'd3);
    feed(pk(7, 7, 7, 7), 1'b1);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = pk(100, 100, 100, 100);
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    model_clear();
    chk("clr_busy", busy, 0);
    chk("clr_valid", out_valid, 0);
    chk("clr_data", out_data, 0);
    chk("clr_ovf", out_ovf, 0);

    // start ignored in DRAIN, then reset in DRAIN
    begin_tile(8'd1);
    feed(pk(9, 0, 0, -9), 1'b1);
    check_result("drn");
    start = 1'b1;
    len   = 8'd5;
    tick();
    start = 1'b0;
    chk("drn_start_ign", out_valid, 1);
    chk("drn_start_data", out_data, exp_data());
    reset = 1'b0;
    #1;
    chk("drn_rst_valid", out_valid, 0);
    chk("drn_rst_busy", busy, 0);
    chk("drn_rst_data", out_data, 0);
    tick();
    reset = 1'b1;
    tick();
    model_clear();
    chk("drn_after_busy", busy, 0);
    chk("drn_after_ready", in_ready, 0);

    // randomized tiles
    for (int t = 0; t < 30; t++) begin
      l = CW'($urandom_range(0, 6));
      eff = (l == 0) ? 1 : int'(l);
      begin_tile(l);
      got = 0;
      while (got < eff) begin
        v = ($urandom_range(0, 3) != 0);
        if (t % 2 == 0)
          d = {$urandom, $urandom};
        else
          d = pk(int'($urandom_range(0, 200)) - 100,
                 int'($urandom_range(0, 200)) - 100,
                 int'($urandom_range(0, 200)) - 100,
                 int'($urandom_range(0, 200)) - 100);
        feed(d, v);
        if (v) got++;
        if (got < eff) chk("rnd_pending", out_valid, 0);
      end
      check_result("rnd");
      finish_drain(int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/matrix_accumulator_array.md
MATRIX_ACCUMULATOR_ARRAY -- requirements
Module: matrix_accumulator_array

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of independent accumulation channels.
REQ-002 SHALL have parameter IN_WIDTH, default 16: signed width of each channel's input operand.
REQ-003 SHALL have parameter ACC_WIDTH, default 32: signed accumulator width, with ACC_WIDTH >= IN_WIDTH.
REQ-004 SHALL have parameter CNT_WIDTH, default 8: width of the beat-count register and of len.
REQ-005 SHALL have port clock, input, 1 bit: single clock, rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port clear, input, 1 bit: synchronous abort/clear.
REQ-008 SHALL have port start, input, 1 bit: begin a tile, sampled in IDLE only.
REQ-009 SHALL have port len, input, CNT_WIDTH bits: beats per tile, latched on start.
REQ-010 SHALL have port in_valid, input, 1 bit: input beat valid.
REQ-011 SHALL have port in_ready, output, 1 bit: block accepts a beat.
REQ-012 SHALL have port in_data, input, N_CH*IN_WIDTH bits: channel k occupies bits [k*IN_WIDTH +: IN_WIDTH].
REQ-013 SHALL have port out_valid, output, 1 bit: tile result valid.
REQ-014 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-015 SHALL have port out_data, output, N_CH*ACC_WIDTH bits: channel k occupies bits [k*ACC_WIDTH +: ACC_WIDTH].
REQ-016 SHALL have port out_ovf, output, N_CH bits: per-channel sticky saturation flag.
REQ-017 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-018 SHALL implement a three-state FSM with states IDLE, ACCUM and DRAIN.
REQ-019 In IDLE, in_ready and out_valid SHALL be 0.
REQ-020 In IDLE, start=1 SHALL latch len (len=0 treated as 1), zero all accumulators, out_ovf and the beat counter, and move to ACCUM on the next cycle.
REQ-021 start SHALL be ignored in ACCUM and DRAIN.
REQ-022 In ACCUM, in_ready SHALL be 1; a beat SHALL be accepted exactly on a cycle with in_valid=1 and in_ready=1.
REQ-023 On each accepted beat, every channel SHALL compute acc_k = sat(acc_k + sign_extend(in_k)).
REQ-024 sat() SHALL clamp to the signed ACC_WIDTH range [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1] and set out_ovf[k], which SHALL stay set until the next start, clear or reset.
REQ-025 Channels SHALL be fully independent; saturation on one channel SHALL NOT affect any other channel.
REQ-026 The beat counter SHALL increment on each accepted beat; acceptance of beat number len SHALL move the FSM to DRAIN on the next cycle.
REQ-027 Latency: final beat accepted at edge T gives out_valid=1 from cycle T+1, with out_data holding the final sums.
REQ-028 Cycles in ACCUM with in_valid=0 SHALL leave all state unchanged.
REQ-029 In DRAIN, in_ready SHALL be 0, out_valid SHALL be 1, and out_data and out_ovf SHALL be stable until out_valid=1 and out_ready=1.
REQ-030 On the DRAIN handshake the FSM SHALL return to IDLE next cycle; accumulators and out_ovf SHALL keep their values until the next start.
REQ-031 out_valid SHALL NOT depend combinationally on out_ready, and in_ready SHALL NOT depend combinationally on in_valid.
REQ-032 out_data SHALL always reflect the accumulator registers, in every state.
REQ-033 clear=1 SHALL take priority over all other inputs: zero accumulators, out_ovf and counter, force IDLE, and drop out_valid next cycle; a beat or start coincident with clear SHALL be discarded.

Reset
REQ-034 reset=0 SHALL asynchronously force IDLE and zero accumulators, counter, latched len and out_ovf; all outputs SHALL be 0 while reset is asserted.
REQ-035 Reset asserted mid-tile (ACCUM or DRAIN) SHALL abort the tile with no out_valid pulse; after release the block SHALL be IDLE and waiting for start.

Verification
REQ-036 Basic tile: N_CH=4, len=3, beats ch0 = 1, 2, 3 and ch3 = -5, -5, -5 with in_valid held high -> out_valid exactly one cycle after the 3rd beat, ch0=6, ch3=-15, out_ovf=0.
REQ-037 Saturation: IN_WIDTH=16, ACC_WIDTH=17, len=4, ch1=32767 on every beat -> ch1=65535 (max), out_ovf[1]=1, all other out_ovf bits 0; negative case ch2=-32768 x4 -> ch2=-65536, out_ovf[2]=1.
REQ-038 Backpressure: hold out_ready=0 for 5 cycles in DRAIN -> out_valid and out_data stable for all 5 cycles, busy=1; out_ready=1 -> IDLE next cycle, busy=0.
REQ-039 Bubbles and len=0: in_valid toggling 1,0,0,1 with len=2 -> sum of the two valid beats only; len=0 -> one beat completes the tile.
REQ-040 Clear and reset mid-tile: clear together with an accepted beat in ACCUM -> beat discarded, IDLE, out_data=0; reset=0 in DRAIN -> out_valid=0 immediately; start ignored in DRAIN.
